decoder2to4_strobe: RTL and testbench
=====================================

# decoder2to4_strobe

Sequential 2-to-4 line decoder that turns a 2-bit binary code into a timed one-hot strobe on four select lines. It is the receive-side counterpart of the 4-to-2 encoder: codes produced by an encoder, or by any control source, are accepted over a valid/ready handshake. Each code drives its one-hot line for a fixed pulse width, followed by a guard gap. Intended for strobe/chip-select generation where a line must stay asserted for several clocks.

## Interface
- PULSE_LEN, default 4: cycles each one-hot pulse stays asserted; legal range 1..255.
- GAP_LEN, default 1: idle cycles forced after each pulse, with all outputs 0; legal range 0..255.
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- in_valid  input  1  in_code is valid this cycle.
- in_ready  output  1  block can accept a code this cycle.
- in_code  input  2  binary code: 0→out[0], 1→out[1], 2→out[2], 3→out[3].
- out  output  4  registered one-hot strobe; all zero when not pulsing.
- out_valid  output  1  high exactly while out is non-zero.
- busy  output  1  high in PULSE or GAP state.
- out_count  output  8  completed-pulse counter; present only with DECODER_COUNT_EN.

## Operation
- State machine states: IDLE, PULSE, GAP. Reset state is IDLE.
- IDLE:
  - in_ready=1, out=0, out_valid=0, busy=0.
  - When in_valid=1, the code is accepted: latch in_code, load cnt=PULSE_LEN-1, go to PULSE.
- PULSE:
  - out = 4'b0001 << code_q; out_valid=1; busy=1; in_ready=0.
  - If cnt==0: go to GAP with cnt=GAP_LEN-1 if GAP_LEN>0, else go to IDLE.
  - Otherwise cnt decrements.
- GAP:
  - out=0, out_valid=0, busy=1, in_ready=0.
  - If cnt==0: go to IDLE; otherwise cnt decrements.
- in_ready is decoded combinationally from state only, with no dependence on in_valid.
- in_valid is ignored outside IDLE: no queueing and no error.
- in_code is don't-care when in_valid=0.
- Counter: 8-bit down-counter shared by PULSE and GAP. Parameters are range-checked at elaboration; an illegal value is a fatal error.
- Reset mid-operation: a low rst_n at any edge forces IDLE, out=0, out_valid=0, busy=0, cnt=0 and out_count=0, then the block waits for a new handshake.
- A handshake presented in the same cycle as rst_n=0 is discarded.

## Timing
- Accept at edge T (IDLE, in_valid=1): out is one-hot from cycle T+1 through T+PULSE_LEN inclusive.
- Outputs are 0 for cycles T+PULSE_LEN+1 .. T+PULSE_LEN+GAP_LEN.
- in_ready rises again at cycle T+1+PULSE_LEN+GAP_LEN. Maximum throughput is one code per PULSE_LEN+GAP_LEN+1 cycles.
- With PULSE_LEN=1 and GAP_LEN=0: single-cycle strobe, and the next accept is possible 2 cycles after the previous one.
- out, out_valid and busy are registered outputs, with no combinational path from in_code to out.
- Reset values: out=0, out_valid=0, busy=0, in_ready=1 in the first cycle after reset, out_count=0.

## Configuration
- DECODER_COUNT_EN defined:
  - out_count port exists.
  - It increments by 1 on the cycle PULSE exits, i.e. once per completed pulse.
  - It wraps 255→0.
  - It clears on reset.
- DECODER_COUNT_EN undefined: the port and its register are absent; all other behaviour is identical.

## Structure
- Shared package decoder_pkg:
  - state enum dec_state_t {IDLE, PULSE, GAP}.
  - constant DEC_CNT_W=8.
  - constant DEC_CODE_W=2.
- One natural sub-module: onehot_dec2to4, a pure combinational code→one-hot decode, instantiated on code_q.
- The FSM, counter and optional out_count live in the top module.

## Test plan
- Reset, then in_code=2 with in_valid=1 for 1 cycle (PULSE_LEN=4, GAP_LEN=1) -> out=4'b0100 for exactly 4 cycles starting 1 cycle after accept; then 1 cycle of 0; in_ready returns 6 cycles after accept.
- All codes 0..3 back-to-back with in_valid held high -> out sequence 0001, 0010, 0100, 1000, each 4 cycles wide; each code is accepted only when in_ready=1, with none lost or duplicated.
- in_valid pulses with code 3 while busy -> ignored; the active pulse stays unchanged; the ignored code is never output.
- PULSE_LEN=1, GAP_LEN=0, continuous valid code 1 -> out=0010 every other cycle; out_valid toggles 1,0,1,0.
- rst_n=0 for one edge in the middle of a PULSE -> out=0 and busy=0 on the next cycle, with in_ready=1; a new code is then decoded normally.
- With DECODER_COUNT_EN: 257 completed pulses -> out_count=1 (wrap); a reset clears it to 0.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and widths for the 2-to-4 strobe decoder.
// Imported by the top module and the one-hot sub-module.
package decoder_pkg;

    localparam int DEC_CNT_W  = 8;
    localparam int DEC_CODE_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } dec_state_t;

endpackage

// File: rtl/onehot_dec2to4.sv
// Pure combinational 2-bit code to 4-bit one-hot decode.
// Used on the latched code so out never sees in_code directly.
module onehot_dec2to4
    import decoder_pkg::*;
(
    input  logic [DEC_CODE_W-1:0] code,
    output logic [3:0]            onehot
);

    // one line per code, exactly one bit set
    always_comb begin
        onehot = 4'b0000;
        unique case (code)
            2'd0: onehot = 4'b0001;
            2'd1: onehot = 4'b0010;
            2'd2: onehot = 4'b0100;
            2'd3: onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
    end

endmodule

// File: rtl/decoder2to4_strobe.sv
// Timed one-hot strobe generator: IDLE -> PULSE -> GAP FSM.
// Optional completed-pulse counter out_count under DECODER_COUNT_EN.
module decoder2to4_strobe
    import decoder_pkg::*;
#(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DEC_CODE_W-1:0] in_code,
    output logic [3:0]            out,
    output logic                  out_valid,
    output logic                  busy
`ifdef DECODER_COUNT_EN
    ,
    output logic [DEC_CNT_W-1:0]  out_count
`endif
);

    if (PULSE_LEN < 1 || PULSE_LEN > 255) begin : g_bad_pulse
        $fatal(1, "PULSE_LEN out of range 1..255");
    end
    if (GAP_LEN < 0 || GAP_LEN > 255) begin : g_bad_gap
        $fatal(1, "GAP_LEN out of range 0..255");
    end

    localparam logic [DEC_CNT_W-1:0] PULSE_LOAD =
        DEC_CNT_W'(PULSE_LEN - 1);
    localparam logic [DEC_CNT_W-1:0] GAP_LOAD =
        DEC_CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam bit HAS_GAP = (GAP_LEN > 0);

    dec_state_t            state;
    logic [DEC_CNT_W-1:0]  cnt;
    logic [DEC_CODE_W-1:0] code_q;
    logic [3:0]            dec;

    onehot_dec2to4 u_dec (
        .code   (code_q),
        .onehot (dec)
    );

    // accept only when idle; readiness never looks at in_valid
    assign in_ready = (state == IDLE);

    // the strobe lines follow the latched code while out_valid is set
    always_comb begin
        out = 4'b0000;
        if (out_valid) begin
            out = dec;
        end
    end

    // FSM, shared down-counter and registered status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            code_q    <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        code_q    <= in_code;
                        cnt       <= PULSE_LOAD;
                        state     <= PULSE;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        out_valid <= 1'b0;
                        if (HAS_GAP) begin
                            state <= GAP;
                            cnt   <= GAP_LOAD;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef DECODER_COUNT_EN
    // count each pulse on the edge that leaves PULSE, wrapping at 255
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_count <= '0;
        end else if (state == PULSE && cnt == '0) begin
            out_count <= out_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_decoder2to4_strobe.sv
// Self-checking bench: default instance (4,1) and a (1,0) instance
// share stimulus and are checked against a timeline model.
module tb_decoder2to4_strobe;

    localparam int P0 = 4;
    localparam int G0 = 1;
    localparam int P1 = 1;
    localparam int G1 = 0;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] in_code;

    logic       rdy0, ov0, bsy0;
    logic [3:0] out0;
    logic       rdy1, ov1, bsy1;
    logic [3:0] out1;
`ifdef DECODER_COUNT_EN
    logic [7:0] cnt_o0, cnt_o1;
`endif

    decoder2to4_strobe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (rdy0),
        .in_code   (in_code),
        .out       (out0),
        .out_valid (ov0),
        .busy      (bsy0)
`ifdef DECODER_COUNT_EN
        ,
        .out_count (cnt_o0)
`endif
    );

    decoder2to4_strobe #(.PULSE_LEN(P1), .GAP_LEN(G1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (rdy1),
        .in_code   (in_code),
        .out       (out1),
        .out_valid (ov1),
        .busy      (bsy1)
`ifdef DECODER_COUNT_EN
        ,
        .out_count (cnt_o1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk;
    int nfail;
    int e;
    int acc0, acc1;
    int code0, code1;
    int pc0, pc1;
    int total0;
    int seen3;

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        nchk++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic busy_at(int acc, int p, int g, int t);
        return (t >= acc) && (t < acc + p + g);
    endfunction

    function automatic logic [3:0] out_at(int acc, int p, int c, int t);
        logic [3:0] one;
        one = 4'b0001;
        if (t >= acc && t < acc + p) return one << c;
        return 4'b0000;
    endfunction

    task automatic check_all();
        logic [3:0] x0, x1;
        x0 = out_at(acc0, P0, code0, e);
        x1 = out_at(acc1, P1, code1, e);
        chk("d0.out", {4'b0, out0}, {4'b0, x0});
        chk("d0.out_valid", {7'b0, ov0}, {7'b0, (x0 != 0)});
        chk("d0.busy", {7'b0, bsy0}, {7'b0, busy_at(acc0, P0, G0, e)});
        chk("d0.in_ready", {7'b0, rdy0}, {7'b0, !busy_at(acc0, P0, G0, e)});
        chk("d1.out", {4'b0, out1}, {4'b0, x1});
        chk("d1.out_valid", {7'b0, ov1}, {7'b0, (x1 != 0)});
        chk("d1.busy", {7'b0, bsy1}, {7'b0, busy_at(acc1, P1, G1, e)});
        chk("d1.in_ready", {7'b0, rdy1}, {7'b0, !busy_at(acc1, P1, G1, e)});
`ifdef DECODER_COUNT_EN
        chk("d0.out_count", cnt_o0, 8'(pc0));
        chk("d1.out_count", cnt_o1, 8'(pc1));
`endif
        if (out0 == 4'b1000 && code0 != 3) seen3++;
    endtask

    // one clock: drive, advance the model timeline, then compare
    task automatic step(logic v, logic [1:0] c, logic r);
        logic a0, a1;
        in_valid = v;
        in_code  = c;
        rst_n    = r;
        a0 = r && v && !busy_at(acc0, P0, G0, e);
        a1 = r && v && !busy_at(acc1, P1, G1, e);
        @(posedge clk);
        #1;
        e++;
        if (!r) begin
            acc0 = -1000;
            acc1 = -1000;
            pc0  = 0;
            pc1  = 0;
        end else begin
            if (acc0 + P0 == e) begin
                pc0 = (pc0 + 1) % 256;
                total0++;
            end
            if (acc1 + P1 == e) pc1 = (pc1 + 1) % 256;
            if (a0) begin acc0 = e; code0 = int'(c); end
            if (a1) begin acc1 = e; code1 = int'(c); end
        end
        check_all();
    endtask

    initial begin
        int q[$];
        int n;
        nchk = 0; nfail = 0; e = 0;
        acc0 = -1000; acc1 = -1000;
        code0 = 0; code1 = 0;
        pc0 = 0; pc1 = 0; total0 = 0; seen3 = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_code = 2'd0;

        // reset with a handshake pending: must be discarded
        step(1'b1, 2'd3, 1'b0);
        step(1'b1, 2'd3, 1'b0);
        chk("reset.out", {4'b0, out0}, 8'h00);
        chk("reset.in_ready", {7'b0, rdy0}, 8'h01);

        // single code 2, then let it drain
        step(1'b1, 2'd2, 1'b1);
        chk("code2.first", {4'b0, out0}, 8'h04);
        for (int i = 0; i < 8; i++) step(1'b0, 2'd0, 1'b1);

        // codes 0..3 back to back with valid held high
        for (int i = 0; i < 4; i++) q.push_back(i);
        n = 0;
        while (q.size() > 0 && n < 60) begin
            logic was_ready;
            was_ready = rdy0;
            step(1'b1, 2'(q[0]), 1'b1);
            if (was_ready) void'(q.pop_front());
            n++;
        end
        chk("b2b.drained", 8'(q.size()), 8'h00);
        for (int i = 0; i < 6; i++) step(1'b0, 2'd0, 1'b1);

        // code 3 offered while busy must never appear
        seen3 = 0;
        step(1'b1, 2'd1, 1'b1);
        for (int i = 0; i < 4; i++) step(i[0], 2'd3, 1'b1);
        chk("busy.ignored3", 8'(seen3), 8'h00);
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b1);

        // reset in the middle of a pulse, then a fresh code
        step(1'b1, 2'd1, 1'b1);
        step(1'b0, 2'd0, 1'b1);
        step(1'b0, 2'd0, 1'b0);
        chk("midrst.busy", {7'b0, bsy0}, 8'h00);
        chk("midrst.ready", {7'b0, rdy0}, 8'h01);
        step(1'b1, 2'd3, 1'b1);
        chk("midrst.new", {4'b0, out0}, 8'h08);
        for (int i = 0; i < 6; i++) step(1'b0, 2'd0, 1'b1);

        // continuous code 1: the (1,0) instance toggles every cycle
        for (int i = 0; i < 8; i++) step(1'b1, 2'd1, 1'b1);

        // random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 2) != 0),
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 39) != 0));
        end

`ifdef DECODER_COUNT_EN
        step(1'b0, 2'd0, 1'b0);
        total0 = 0;
        n = 0;
        while (total0 < 257 && n < 257 * 8) begin
            step(1'b1, 2'($urandom_range(0, 3)), 1'b1);
            n++;
        end
        chk("count.done", 8'(total0 == 257), 8'h01);
        chk("count.wrap", cnt_o0, 8'h01);
        step(1'b0, 2'd0, 1'b0);
        chk("count.clear", cnt_o0, 8'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
